lsu_mem_fsm: RTL

//  Parametrised load/store unit replacing the fixed single-cycle LSU. It issues one data-memory

---
 rtl/lsu_mem_fsm_if.sv | 47 ++++
 rtl/lsu_mem_fsm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_fsm_if.sv
// Data-memory bus shared by the LSU (master) and memory (slave), plus the EX instruction type enum.

package lsu_mem_pkg;

  typedef enum logic [3:0] {
    InstrOther,
    InstrLb,
    InstrLh,
    InstrLw,
    InstrLbu,
    InstrLhu,
    InstrSb,
    InstrSh,
    InstrSw,
    InstrAdd,
    InstrBeq
  } rv32i_instr_e;

endpackage

interface lsu_mem_fsm_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  localparam int unsigned Lanes = DATA_W / 8;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [Lanes-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_mem_fsm.sv
// Multi-cycle load/store unit: one req/gnt/rvalid transaction per load/store, EX held until done.

module lsu_mem_fsm
  import lsu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  rv32i_instr_e       id_ex_instr_type_i,
  input  logic [ADDR_W-1:0]  ex_addr_i,
  input  logic [31:0]        id_ex_rs2_data_i,
  output logic               lsu_stall_o,
  output logic               misalign_err_o,
  output logic               bus_err_o,
  output logic               wb_lsu_write_sel_o,
  output logic [31:0]        wb_load_result_o,
  lsu_mem_fsm_if.master      mem
);

  localparam int unsigned Lanes = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(Lanes);
  localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [Lanes-1:0]    mem_be_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  rv32i_instr_e        type_q;
  logic [OffW-1:0]     off_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aborted_q;
  logic                bus_err_q;
  logic                wb_sel_q;
  logic [31:0]         wb_result_q;

  logic                is_load;
  logic                is_store;
  logic [1:0]          size_ex;   // 0 = byte, 1 = half, 2 = word
  logic [OffW-1:0]     off_ex;
  logic                misaligned;
  logic                aligned_op;
  logic [Lanes-1:0]    be_ex;
  logic [DATA_W-1:0]   wdata_ex;
  logic [ADDR_W-1:0]   addr_ex;
  logic [31:0]         load_x;
  logic [31:0]         load_ext;

  assign off_ex = ex_addr_i[OffW-1:0];

  // Decode the EX instruction into access kind and size.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_ex  = 2'd0;
    case (id_ex_instr_type_i)
      InstrLb, InstrLbu: begin is_load  = 1'b1; size_ex = 2'd0; end
      InstrLh, InstrLhu: begin is_load  = 1'b1; size_ex = 2'd1; end
      InstrLw:           begin is_load  = 1'b1; size_ex = 2'd2; end
      InstrSb:           begin is_store = 1'b1; size_ex = 2'd0; end
      InstrSh:           begin is_store = 1'b1; size_ex = 2'd1; end
      InstrSw:           begin is_store = 1'b1; size_ex = 2'd2; end
      default: ;
    endcase
  end

  assign misaligned     = ((size_ex == 2'd1) && off_ex[0]) ||
                          ((size_ex == 2'd2) && (off_ex[1:0] != 2'b00));
  assign misalign_err_o = (is_load || is_store) && misaligned;
  assign aligned_op     = (is_load || is_store) && !misaligned;
  assign addr_ex        = {ex_addr_i[ADDR_W-1:OffW], {OffW{1'b0}}};

  // Byte enables and lane-shifted store data for the EX access.
  always_comb begin
    logic [Lanes-1:0]  be_base;
    logic [DATA_W-1:0] wd_base;
    be_base = '0;
    wd_base = '0;
    case (size_ex)
      2'd0: begin be_base[0]   = 1'b1;    wd_base[7:0]  = id_ex_rs2_data_i[7:0];  end
      2'd1: begin be_base[1:0] = 2'b11;   wd_base[15:0] = id_ex_rs2_data_i[15:0]; end
      default: begin be_base[3:0] = 4'hF; wd_base[31:0] = id_ex_rs2_data_i;       end
    endcase
    be_ex    = be_base << off_ex;
    wdata_ex = wd_base << {off_ex, 3'b000};
  end

  // Extract and extend the held load data using the latched offset and type.
  always_comb begin
    load_x   = 32'(rdata_q >> {off_q, 3'b000});
    load_ext = load_x;
    case (type_q)
      InstrLb:  load_ext = {{24{load_x[7]}}, load_x[7:0]};
      InstrLbu: load_ext = {24'h0, load_x[7:0]};
      InstrLh:  load_ext = {{16{load_x[15]}}, load_x[15:0]};
      InstrLhu: load_ext = {16'h0, load_x[15:0]};
      default:  load_ext = load_x;
    endcase
  end

  // Transaction FSM with registered bus and writeback outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      type_q      <= InstrOther;
      off_q       <= '0;
      rdata_q     <= '0;
      aborted_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      wb_sel_q    <= 1'b0;
      wb_result_q <= '0;
    end else begin
      bus_err_q <= 1'b0;
      wb_sel_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (aligned_op && !stall_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_store;
            mem_addr_q  <= addr_ex;
            mem_be_q    <= be_ex;
            mem_wdata_q <= wdata_ex;
            type_q      <= id_ex_instr_type_i;
            off_q       <= off_ex;
            cnt_q       <= '0;
            aborted_q   <= 1'b0;
            state_q     <= StReq;
          end
        end
        StReq: begin
          cnt_q <= cnt_q + 1'b1;
          // A response in the grant cycle completes the access; it beats the timeout.
          if (mem.mem_gnt && mem.mem_rvalid) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) rdata_q <= mem.mem_rdata;
            state_q   <= StDone;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            aborted_q <= 1'b1;
            state_q   <= StDone;
          end else if (mem.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem.mem_rvalid) begin
            if (!mem_we_q) rdata_q <= mem.mem_rdata;
            state_q <= StDone;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            bus_err_q <= 1'b1;
            aborted_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (!stall_i) begin
            state_q <= StIdle;
            if (!mem_we_q && !aborted_q) begin
              wb_sel_q    <= 1'b1;
              wb_result_q <= load_ext;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lsu_stall_o = ((state_q == StIdle) && aligned_op) ||
                       (state_q == StReq) || (state_q == StWait);

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign bus_err_o          = bus_err_q;
  assign wb_lsu_write_sel_o = wb_sel_q;
  assign wb_load_result_o   = wb_result_q;

endmodule
